// File: rtl/pmod_gpio_remap_sync.sv
// pmod_gpio_remap_sync: Pmod GPIO remap between a flat AXI-GPIO-style bus
// and NUM_ROWS Pmod bridge rows (N = ROW_WIDTH*NUM_ROWS pins).
//
// Output path: gpio_in_tri_t/o -> gpio_out_tri_t/o, bit-for-bit.
//   Row r occupies bits [r*ROW_WIDTH +: ROW_WIDTH]; row 0 is the top row.
//   Define PMOD_REMAP_OUT_REG_EN to register the output path (1-cycle
//   latency; reset to tri_t = all 1s, tri_o = 0). When it is undefined,
//   the output path is combinational.
// Input path: gpio_out_tri_i -> SYNC_STAGES synchroniser -> per-pin
//   debounce (DB_CYCLES stable cycles) -> gpio_in_tri_i.
//   Debounced edges, gated by rise_mask/fall_mask, set sticky irq_status.
//   irq_clear is write-1-to-clear, and a new event wins over a clear.
//   irq is the OR of irq_status.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   gpio_in_tri_t/o     tristate enable / data from AXI GPIO
//   gpio_in_tri_i       debounced pin state to AXI GPIO
//   gpio_out_tri_t/o    tristate enable / data to the bridge rows
//   gpio_out_tri_i      raw pin input from the bridge rows
//   rise_mask/fall_mask per-pin edge enables for status
//   irq_clear           per-pin status clear
//   irq_status, irq     sticky status and its OR-reduction
module pmod_gpio_remap_sync #(
    parameter int ROW_WIDTH   = 4,
    parameter int NUM_ROWS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter logic [ROW_WIDTH*NUM_ROWS-1:0] INIT_VAL = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_in_tri_t,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_in_tri_o,
    output logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_in_tri_i,
    output logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_out_tri_t,
    output logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_out_tri_o,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   gpio_out_tri_i,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   rise_mask,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   fall_mask,
    input  logic [ROW_WIDTH*NUM_ROWS-1:0]   irq_clear,
    output logic [ROW_WIDTH*NUM_ROWS-1:0]   irq_status,
    output logic                            irq
);

    localparam int N  = ROW_WIDTH * NUM_ROWS;
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Synchroniser chain; stage SYNC_STAGES-1 is the pin value seen by
    // the debouncer.
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];
    logic [N-1:0] s;

    always_comb begin
        sync_d[0] = gpio_out_tri_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= INIT_VAL;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a pin must differ from db for DB_CYCLES consecutive
    // samples before db follows it. Any sample equal to db restarts.
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [N-1:0]  db_q;
    logic [N-1:0]  db_d;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (s[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q <= INIT_VAL;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_in_tri_i = db_q;

    // Edge events are taken from db_d so that status sets on the same
    // edge that db changes.
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] ev;
    logic [N-1:0] status_q;
    logic [N-1:0] status_d;

    always_comb begin
        rise     = db_d & ~db_q;
        fall     = ~db_d & db_q;
        ev       = (rise & rise_mask) | (fall & fall_mask);
        status_d = (status_q & ~irq_clear) | ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign irq_status = status_q;
    assign irq        = |status_q;

`ifdef PMOD_REMAP_OUT_REG_EN
    // Registered output path; pins come out of reset as inputs (hi-Z).
    logic [N-1:0] tri_t_q;
    logic [N-1:0] tri_t_d;
    logic [N-1:0] tri_o_q;
    logic [N-1:0] tri_o_d;

    always_comb begin
        tri_t_d = gpio_in_tri_t;
        tri_o_d = gpio_in_tri_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tri_t_q <= '1;
            tri_o_q <= '0;
        end else begin
            tri_t_q <= tri_t_d;
            tri_o_q <= tri_o_d;
        end
    end

    assign gpio_out_tri_t = tri_t_q;
    assign gpio_out_tri_o = tri_o_q;
`else
    assign gpio_out_tri_t = gpio_in_tri_t;
    assign gpio_out_tri_o = gpio_in_tri_o;
`endif

endmodule
